dataload_multi: RTL and testbench

DATALOAD_MULTI -- requirements
Module: dataload_multi

---
 rtl/dataload_multi_if.sv | 50 +++++
 rtl/dataload_multi.sv | 127 ++++++++++++
 tb/tb_dataload_multi.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dataload_multi_if.sv
// Load bus between a word source, the dataload_multi buffers and the block
// consumers. Groups the word stream, the buffer-ready flag, the flush
// request, and the two assembled-block outputs with their acknowledges.
//
// Handshake semantics:
//   word path  : a word on data_i is taken at a rising edge when
//                load_en_i=1 and load_rdy_o=1. load_rdy_o reflects the
//                buffer chosen by load_type (0 = weight, 1 = input). It comes
//                from registered state only. A word offered while
//                load_rdy_o=0 is dropped, not held.
//   block path : weight_valid / input_valid stay high, with the block stable,
//                until the matching *_ack_i is seen high at a rising edge.
//                The buffer is then empty on the following cycle. An ack
//                while valid=0 has no effect.
interface dataload_multi_if #(
    parameter int DATA_W   = 32,
    parameter int IN_WORDS = 8,
    parameter int W_WORDS  = 1
);
    localparam int IN_CW = $clog2(IN_WORDS + 1);
    localparam int W_CW  = $clog2(W_WORDS + 1);

    logic [DATA_W-1:0]          data_i;
    logic                       load_en_i;
    logic                       load_type;
    logic                       load_rdy_o;
    logic                       flush_i;
    logic [W_WORDS*DATA_W-1:0]  weight_o;
    logic                       weight_valid;
    logic                       weight_ack_i;
    logic [IN_WORDS*DATA_W-1:0] first_level_input_data;
    logic                       input_valid;
    logic                       input_ack_i;
    logic [W_CW-1:0]            weight_cnt_o;
    logic [IN_CW-1:0]           input_cnt_o;

    // Source / consumer side
    modport master (
        output data_i, load_en_i, load_type, flush_i, weight_ack_i, input_ack_i,
        input  load_rdy_o, weight_o, weight_valid, first_level_input_data,
               input_valid, weight_cnt_o, input_cnt_o
    );

    // Buffer side
    modport slave (
        input  data_i, load_en_i, load_type, flush_i, weight_ack_i, input_ack_i,
        output load_rdy_o, weight_o, weight_valid, first_level_input_data,
               input_valid, weight_cnt_o, input_cnt_o
    );
endinterface

// File: rtl/dataload_multi.sv
// Two independent word-packing buffers, one for weights and one for inputs.
// Words arrive one per cycle and are packed low slot first. When a buffer
// holds a full block it raises valid and refuses further words until the
// consumer acknowledges. Flush empties both buffers, and reset overrides
// everything else.
module dataload_multi #(
    parameter int DATA_W   = 32,
    parameter int IN_WORDS = 8,
    parameter int W_WORDS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    dataload_multi_if.slave  bus,
    // Debug view of the buffer states: [1] input FULL, [0] weight FULL
    output logic [1:0]       o_dbg_state
);
    localparam int IN_CW = $clog2(IN_WORDS + 1);
    localparam int W_CW  = $clog2(W_WORDS + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                     r_w_state, w_w_state_nxt;
    state_t                     r_i_state, w_i_state_nxt;
    logic [W_CW-1:0]            r_w_cnt;
    logic [IN_CW-1:0]           r_i_cnt;
    logic [W_WORDS*DATA_W-1:0]  r_w_data;
    logic [IN_WORDS*DATA_W-1:0] r_i_data;
    logic                       w_w_accept, w_w_clear;
    logic                       w_i_accept, w_i_clear;

    // Weight buffer: decide acceptance, FULL transition on the last word, release on ack
    always_comb begin
        w_w_state_nxt = r_w_state;
        w_w_accept    = 1'b0;
        w_w_clear     = 1'b0;
        case (r_w_state)
            S_FILL: begin
                if (bus.load_en_i && !bus.load_type) begin
                    w_w_accept = 1'b1;
                    if (r_w_cnt == W_CW'(W_WORDS - 1)) w_w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.weight_ack_i) begin
                    w_w_clear     = 1'b1;
                    w_w_state_nxt = S_FILL;
                end
            end
            default: w_w_state_nxt = S_FILL;
        endcase
    end

    // Input buffer: same rules as the weight buffer, selected by load_type=1
    always_comb begin
        w_i_state_nxt = r_i_state;
        w_i_accept    = 1'b0;
        w_i_clear     = 1'b0;
        case (r_i_state)
            S_FILL: begin
                if (bus.load_en_i && bus.load_type) begin
                    w_i_accept = 1'b1;
                    if (r_i_cnt == IN_CW'(IN_WORDS - 1)) w_i_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.input_ack_i) begin
                    w_i_clear     = 1'b1;
                    w_i_state_nxt = S_FILL;
                end
            end
            default: w_i_state_nxt = S_FILL;
        endcase
    end

    // Weight state, count and packed data; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            r_w_state <= S_FILL;
            r_w_cnt   <= '0;
            r_w_data  <= '0;
        end else begin
            r_w_state <= w_w_state_nxt;
            if (w_w_clear) begin
                r_w_cnt  <= '0;
                r_w_data <= '0;
            end else if (w_w_accept) begin
                r_w_cnt <= r_w_cnt + 1'b1;
                for (int k = 0; k < W_WORDS; k++) begin
                    if (r_w_cnt == W_CW'(k)) r_w_data[k*DATA_W +: DATA_W] <= bus.data_i;
                end
            end
        end
    end

    // Input state, count and packed data; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            r_i_state <= S_FILL;
            r_i_cnt   <= '0;
            r_i_data  <= '0;
        end else begin
            r_i_state <= w_i_state_nxt;
            if (w_i_clear) begin
                r_i_cnt  <= '0;
                r_i_data <= '0;
            end else if (w_i_accept) begin
                r_i_cnt <= r_i_cnt + 1'b1;
                for (int k = 0; k < IN_WORDS; k++) begin
                    if (r_i_cnt == IN_CW'(k)) r_i_data[k*DATA_W +: DATA_W] <= bus.data_i;
                end
            end
        end
    end

    // Ready follows the selected buffer's registered state; valids are the FULL states
    assign bus.load_rdy_o = bus.load_type ? (r_i_state == S_FILL) : (r_w_state == S_FILL);
    assign bus.weight_valid           = (r_w_state == S_FULL);
    assign bus.input_valid            = (r_i_state == S_FULL);
    assign bus.weight_o               = r_w_data;
    assign bus.first_level_input_data = r_i_data;
    assign bus.weight_cnt_o           = r_w_cnt;
    assign bus.input_cnt_o            = r_i_cnt;
    assign o_dbg_state                = {r_i_state == S_FULL, r_w_state == S_FULL};
endmodule

// File: tb/tb_dataload_multi.sv
// Bench for dataload_multi: a default-parameter instance driven by directed
// scenarios and then random traffic, checked every cycle against a
// queue-based model of the two buffers, plus a 16-bit / 4-word / 2-word
// instance checked with directed packing cases.
module tb_dataload_multi;
    localparam int DW  = 32;
    localparam int INW = 8;
    localparam int WW  = 1;

    localparam int B_DW  = 16;
    localparam int B_INW = 4;
    localparam int B_WW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    dataload_multi_if #(.DATA_W(DW), .IN_WORDS(INW), .W_WORDS(WW)) bus ();
    dataload_multi_if #(.DATA_W(B_DW), .IN_WORDS(B_INW), .W_WORDS(B_WW)) bus_b ();
    logic [1:0] dbg_a, dbg_b;

    dataload_multi #(.DATA_W(DW), .IN_WORDS(INW), .W_WORDS(WW)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_a)
    );

    dataload_multi #(.DATA_W(B_DW), .IN_WORDS(B_INW), .W_WORDS(B_WW)) u_dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .o_dbg_state(dbg_b)
    );

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A buffer is simply the list of words accepted since it was last emptied.
    // It is full when the list holds a whole block.
    logic [DW-1:0]         m_in[$];
    logic [DW-1:0]         m_w[$];
    logic [INW*DW-1:0]     exp_in_q[$];
    logic [WW*DW-1:0]      exp_w_q[$];

    function automatic logic [INW*DW-1:0] pack_in();
        logic [INW*DW-1:0] p = '0;
        foreach (m_in[k]) p[k*DW +: DW] = m_in[k];
        return p;
    endfunction

    function automatic logic [WW*DW-1:0] pack_w();
        logic [WW*DW-1:0] p = '0;
        foreach (m_w[k]) p[k*DW +: DW] = m_w[k];
        return p;
    endfunction

    task automatic model_step(input logic en, input logic typ, input logic [DW-1:0] d,
                              input logic wa, input logic ia, input logic fl, input logic r);
        if (r || fl) begin
            m_in.delete();
            m_w.delete();
        end else begin
            if (m_w.size() == WW) begin
                if (wa) m_w.delete();
            end else if (en && !typ) begin
                m_w.push_back(d);
                if (m_w.size() == WW) exp_w_q.push_back(pack_w());
            end
            if (m_in.size() == INW) begin
                if (ia) m_in.delete();
            end else if (en && typ) begin
                m_in.push_back(d);
                if (m_in.size() == INW) exp_in_q.push_back(pack_in());
            end
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge and the model absorbs
    // them at the next rising edge, the same edge where the DUT samples them.
    task automatic cycle(input logic en, input logic typ, input logic [DW-1:0] d,
                         input logic wa, input logic ia, input logic fl, input logic r);
        bus.load_en_i    = en;
        bus.load_type    = typ;
        bus.data_i       = d;
        bus.weight_ack_i = wa;
        bus.input_ack_i  = ia;
        bus.flush_i      = fl;
        rst              = r;
        @(posedge clk);
        model_step(en, typ, d, wa, ia, fl, r);
        #1;
    endtask

    task automatic load(input logic typ, input logic [DW-1:0] d);
        cycle(1'b1, typ, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic b_cycle(input logic en, input logic typ, input logic [B_DW-1:0] d,
                           input logic r);
        bus_b.load_en_i    = en;
        bus_b.load_type    = typ;
        bus_b.data_i       = d;
        bus_b.weight_ack_i = 1'b0;
        bus_b.input_ack_i  = 1'b0;
        bus_b.flush_i      = 1'b0;
        rst_b              = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic mon_en  = 1'b0;
    logic prev_iv = 1'b0;
    logic prev_wv = 1'b0;

    // Away from the active edge, compare the DUT against the model and pop a
    // completed block from the scoreboard each time a valid rises.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("input_cnt", bus.input_cnt_o, m_in.size());
            chk("weight_cnt", bus.weight_cnt_o, m_w.size());
            chk("input_valid", bus.input_valid, m_in.size() == INW);
            chk("weight_valid", bus.weight_valid, m_w.size() == WW);
            chk("load_rdy", bus.load_rdy_o,
                bus.load_type ? (m_in.size() < INW) : (m_w.size() < WW));
            chk("input_data", bus.first_level_input_data, pack_in());
            chk("weight_data", bus.weight_o, pack_w());
            if (bus.input_valid === 1'b1 && !prev_iv) begin
                if (exp_in_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_input: got block %0h, expected no block", bus.first_level_input_data);
                end else begin
                    chk("sb_input", bus.first_level_input_data, exp_in_q.pop_front());
                end
            end
            if (bus.weight_valid === 1'b1 && !prev_wv) begin
                if (exp_w_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_weight: got block %0h, expected no block", bus.weight_o);
                end else begin
                    chk("sb_weight", bus.weight_o, exp_w_q.pop_front());
                end
            end
            prev_iv = (bus.input_valid === 1'b1);
            prev_wv = (bus.weight_valid === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_b = 1'b1;
        bus_b.load_en_i = 1'b0; bus_b.load_type = 1'b0; bus_b.data_i = '0;
        bus_b.weight_ack_i = 1'b0; bus_b.input_ack_i = 1'b0; bus_b.flush_i = 1'b0;

        // Reset, then start checking every cycle
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_rdy_input", bus.load_rdy_o, 1'b1);
        chk("rst_input_data", bus.first_level_input_data, '0);
        chk("rst_weight_valid", bus.weight_valid, 1'b0);

        // Eight input words 1..8 make one block, weight side untouched
        for (int k = 1; k <= 8; k++) load(1'b1, DW'(k));
        chk("blk1_valid", bus.input_valid, 1'b1);
        chk("blk1_data", bus.first_level_input_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        chk("blk1_cnt", bus.input_cnt_o, 4'd8);
        chk("blk1_weight_cnt", bus.weight_cnt_o, 1'b0);

        // Ninth word is refused while full; ack empties; next word lands low
        load(1'b1, 32'hDEAD);
        chk("full_rdy", bus.load_rdy_o, 1'b0);
        chk("full_data_kept", bus.first_level_input_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_valid", bus.input_valid, 1'b0);
        chk("ack_cnt", bus.input_cnt_o, 4'd0);
        load(1'b1, 32'hA);
        chk("after_ack_word", bus.first_level_input_data, 256'hA);

        // Single weight word fills the weight buffer; input keeps filling alongside
        load(1'b0, 32'h12345678);
        chk("w_valid", bus.weight_valid, 1'b1);
        chk("w_data", bus.weight_o, 256'h12345678);
        load(1'b1, 32'hB);
        load(1'b0, 32'hFFFF);
        load(1'b1, 32'hC);
        chk("interleave_data", bus.first_level_input_data, 256'h0000000C_0000000B_0000000A);
        chk("w_data_kept", bus.weight_o, 256'h12345678);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("w_ack_valid", bus.weight_valid, 1'b0);

        // Flush with a concurrent load: nothing stored
        cycle(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_cnt", bus.input_cnt_o, 4'd0);
        chk("flush_data", bus.first_level_input_data, '0);

        // Five words, then reset with load_en high, then a clean block
        for (int k = 0; k < 5; k++) load(1'b1, DW'(32'h50 + k));
        cycle(1'b1, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_cnt", bus.input_cnt_o, 4'd0);
        chk("mid_rst_data", bus.first_level_input_data, '0);
        for (int k = 0; k < 8; k++) load(1'b1, DW'(32'h10 + k));
        chk("clean_blk", bus.first_level_input_data,
            256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
        end
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("sb_input_drained", exp_in_q.size(), 0);
        chk("sb_weight_drained", exp_w_q.size(), 0);

        // Narrow instance: 16-bit words, 4-word input block, 2-word weight block
        b_cycle(1'b0, 1'b1, '0, 1'b1);
        b_cycle(1'b0, 1'b1, '0, 1'b0);
        chk("b_rst_data", bus_b.first_level_input_data, '0);
        b_cycle(1'b1, 1'b1, 16'h1111, 1'b0);
        b_cycle(1'b1, 1'b1, 16'h2222, 1'b0);
        b_cycle(1'b1, 1'b1, 16'h3333, 1'b0);
        chk("b_in_partial_valid", bus_b.input_valid, 1'b0);
        chk("b_in_partial_cnt", bus_b.input_cnt_o, 3'd3);
        b_cycle(1'b1, 1'b1, 16'h4444, 1'b0);
        chk("b_in_valid", bus_b.input_valid, 1'b1);
        chk("b_in_data", bus_b.first_level_input_data, 64'h4444_3333_2222_1111);
        b_cycle(1'b1, 1'b0, 16'hAAAA, 1'b0);
        chk("b_w_partial_valid", bus_b.weight_valid, 1'b0);
        chk("b_w_partial_data", bus_b.weight_o, 32'h0000_AAAA);
        b_cycle(1'b1, 1'b0, 16'hBBBB, 1'b0);
        chk("b_w_valid", bus_b.weight_valid, 1'b1);
        chk("b_w_data", bus_b.weight_o, 32'hBBBB_AAAA);
        chk("b_w_cnt", bus_b.weight_cnt_o, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
